// File: rtl/rect_draw_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : rect_draw_scheduler_if
// Brief    : Command, completion and renderer bundle for rect_draw_scheduler.
// Revision : 1.0
// ============================================================================
interface rect_draw_scheduler_if #(
    parameter int COLOR_W = 3
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [17:0]          req_x;
    logic [15:0]          req_y;
    logic [17:0]          req_w;
    logic [15:0]          req_h;
    logic [2*COLOR_W-1:0] req_back;
    logic [1:0]           req_border;
    logic [2*COLOR_W-1:0] req_bcolor;

    logic                 cmp_valid;
    logic                 cmp_id;
    logic [1:0]           cmp_status;
    logic                 busy;

    logic                 rr_enable;
    logic [8:0]           rr_origin_x;
    logic [7:0]           rr_origin_y;
    logic [8:0]           rr_width;
    logic [7:0]           rr_height;
    logic [COLOR_W-1:0]   rr_back;
    logic [COLOR_W-1:0]   rr_bcolor;
    logic                 rr_border;
    logic                 rr_done;

    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h,
               req_back, req_border, req_bcolor, rr_done,
        output req_ready, cmp_valid, cmp_id, cmp_status, busy,
               rr_enable, rr_origin_x, rr_origin_y, rr_width, rr_height,
               rr_back, rr_bcolor, rr_border
    );

    modport master (
        output req_valid, req_x, req_y, req_w, req_h,
               req_back, req_border, req_bcolor, rr_done,
        input  req_ready, cmp_valid, cmp_id, cmp_status, busy,
               rr_enable, rr_origin_x, rr_origin_y, rr_width, rr_height,
               rr_back, rr_bcolor, rr_border
    );
endinterface
`default_nettype wire

// File: rtl/rect_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rect_draw_scheduler
// Brief    : Round-robin front end for two rectangle requesters; sequences the
//            shared renderer through one enable/done cycle per command.
// Revision : 1.0
// ============================================================================
module rect_draw_scheduler #(
    parameter int COLOR_W = 3,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 131071
) (
    input  logic                 clk,
    input  logic                 reset,
    rect_draw_scheduler_if.slave bus
);

    localparam int c_RUN_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int c_SETTLE_W = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [c_RUN_W-1:0]    c_RUN_LAST   = c_RUN_W'(TIMEOUT - 1);
    localparam logic [c_SETTLE_W-1:0] c_SETTLE_MAX = c_SETTLE_W'(SETTLE);
    localparam logic [8:0]            c_X_LIMIT    = 9'd320;
    localparam logic [7:0]            c_Y_LIMIT    = 8'd240;

    localparam logic [1:0] c_ST_DRAWN   = 2'b00;
    localparam logic [1:0] c_ST_SKIPPED = 2'b01;
    localparam logic [1:0] c_ST_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_RUN      = 3'd2,
        S_RELEASE  = 3'd3,
        S_COMPLETE = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                  r_last_grant;
    logic                  r_owner;
    logic [1:0]            r_status;
    logic [c_RUN_W-1:0]    r_run_cnt;
    logic [c_SETTLE_W-1:0] r_settle_cnt;
    logic [8:0]            r_x;
    logic [7:0]            r_y;
    logic [8:0]            r_w;
    logic [7:0]            r_h;
    logic [COLOR_W-1:0]    r_back;
    logic [COLOR_W-1:0]    r_bcolor;
    logic                  r_border;

    logic                  w_grant;
    logic                  w_accept;
    logic                  w_skip;
    logic                  w_done_ok;
    logic                  w_timeout;
    logic [1:0]            w_ready;
    logic                  w_rr_enable;
    logic                  w_cmp_valid;
    logic [8:0]            w_x;
    logic [7:0]            w_y;
    logic [8:0]            w_w;
    logic [7:0]            w_h;
    logic [COLOR_W-1:0]    w_back;
    logic [COLOR_W-1:0]    w_bcolor;
    logic                  w_border;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        if (bus.req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = bus.req_valid[1];
        end
    end

    assign w_x      = w_grant ? bus.req_x[17:9] : bus.req_x[8:0];
    assign w_y      = w_grant ? bus.req_y[15:8] : bus.req_y[7:0];
    assign w_w      = w_grant ? bus.req_w[17:9] : bus.req_w[8:0];
    assign w_h      = w_grant ? bus.req_h[15:8] : bus.req_h[7:0];
    assign w_back   = w_grant ? bus.req_back[2*COLOR_W-1:COLOR_W]
                              : bus.req_back[COLOR_W-1:0];
    assign w_bcolor = w_grant ? bus.req_bcolor[2*COLOR_W-1:COLOR_W]
                              : bus.req_bcolor[COLOR_W-1:0];
    assign w_border = w_grant ? bus.req_border[1] : bus.req_border[0];

    // Degenerate or off-screen rectangles never reach the renderer.
    assign w_skip = (w_w == 9'd0) || (w_h == 8'd0) ||
                    (w_x >= c_X_LIMIT) || (w_y >= c_Y_LIMIT);

    assign w_accept  = (r_state == S_IDLE) && (bus.req_valid != 2'b00);
    assign w_done_ok = bus.rr_done && (r_settle_cnt == c_SETTLE_MAX);
    assign w_timeout = (r_run_cnt == c_RUN_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ready     = 2'b00;
        w_rr_enable = 1'b0;
        w_cmp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_ready = w_grant ? 2'b10 : 2'b01;
                    w_next  = w_skip ? S_COMPLETE : S_SETUP;
                end
            end
            S_SETUP: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                w_rr_enable = 1'b1;
                if (w_done_ok || w_timeout) begin
                    w_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_cmp_valid = 1'b1;
                w_next      = S_IDLE;
            end
            S_COMPLETE: begin
                w_cmp_valid = 1'b1;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_status     <= 2'b00;
            r_run_cnt    <= '0;
            r_settle_cnt <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_h          <= '0;
            r_back       <= '0;
            r_bcolor     <= '0;
            r_border     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x          <= w_x;
                r_y          <= w_y;
                r_w          <= w_w;
                r_h          <= w_h;
                r_back       <= w_back;
                r_bcolor     <= w_bcolor;
                r_border     <= w_border;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_skip) begin
                    r_status <= c_ST_SKIPPED;
                end
            end
            if (r_state == S_RUN) begin
                r_run_cnt <= r_run_cnt + 1'b1;
                if (r_settle_cnt != c_SETTLE_MAX) begin
                    r_settle_cnt <= r_settle_cnt + 1'b1;
                end
                // A genuine done wins over a simultaneous timeout.
                if (w_done_ok) begin
                    r_status <= c_ST_DRAWN;
                end else if (w_timeout) begin
                    r_status <= c_ST_TIMEOUT;
                end
            end else begin
                r_run_cnt    <= '0;
                r_settle_cnt <= '0;
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.cmp_valid   = w_cmp_valid;
    assign bus.cmp_id      = r_owner;
    assign bus.cmp_status  = r_status;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.rr_enable   = w_rr_enable;
    assign bus.rr_origin_x = r_x;
    assign bus.rr_origin_y = r_y;
    assign bus.rr_width    = r_w;
    assign bus.rr_height   = r_h;
    assign bus.rr_back     = r_back;
    assign bus.rr_bcolor   = r_bcolor;
    assign bus.rr_border   = r_border;

endmodule
`default_nettype wire

// File: tb/tb_rect_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rect_draw_scheduler
// Brief    : Scoreboard bench for rect_draw_scheduler with a renderer model.
// Revision : 1.0
// ============================================================================
module tb_rect_draw_scheduler;

    localparam int COLOR_W = 3;
    localparam int SETTLE  = 3;
    // Shortened so the stuck-done case stays brief; long draws scale to fit.
    localparam int TIMEOUT = 2000;

    logic clk = 1'b0;
    logic reset;

    rect_draw_scheduler_if #(.COLOR_W(COLOR_W)) bus ();

    rect_draw_scheduler #(
        .COLOR_W (COLOR_W),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] sb[$];
    int spur_cycles = 0;
    int done_after  = 0;
    int en_cnt      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Renderer model: spurious done for the first spur_cycles enable cycles,
    // then real done from enable cycle done_after onward (0 = never).
    always @(negedge clk) begin
        if (bus.rr_enable) en_cnt = en_cnt + 1;
        else en_cnt = 0;
        bus.rr_done = bus.rr_enable &&
                      ((en_cnt <= spur_cycles) || (done_after > 0 && en_cnt >= done_after));
    end

    always @(negedge clk) begin
        logic [2:0] e;
        if (!reset) begin
            if (bus.req_ready != 2'b00) begin
                check("ready_onehot", $countones(bus.req_ready), 1);
                check("ready_vs_cmp", bus.cmp_valid, 0);
            end
            if (bus.cmp_valid) begin
                if (sb.size() == 0) begin
                    check("cmp_unexpected", bus.cmp_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("cmp_id", bus.cmp_id, e[2]);
                    check("cmp_status", bus.cmp_status, e[1:0]);
                end
            end
        end
    end

    function automatic void run_model(input int spur, input int dafter,
                                      output int len, output logic [1:0] st);
        len = TIMEOUT;
        st  = 2'b10;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k > SETTLE && (k <= spur || (dafter > 0 && k >= dafter))) begin
                len = k;
                st  = 2'b00;
                break;
            end
        end
    endfunction

    task automatic drive_cmd(input int idx, input logic [8:0] x, input logic [7:0] y,
                             input logic [8:0] w, input logic [7:0] h);
        bus.req_x[idx*9 +: 9]                = x;
        bus.req_y[idx*8 +: 8]                = y;
        bus.req_w[idx*9 +: 9]                = w;
        bus.req_h[idx*8 +: 8]                = h;
        bus.req_back[idx*COLOR_W +: COLOR_W]   = COLOR_W'(idx + 2);
        bus.req_bcolor[idx*COLOR_W +: COLOR_W] = COLOR_W'(idx + 5);
        bus.req_border[idx]                  = 1'b1;
        bus.req_valid[idx]                   = 1'b1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && bus.busy; i++) @(negedge clk);
        check("wait_idle", bus.busy, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_cmd(input int idx, input logic [8:0] x, input logic [7:0] y,
                           input logic [8:0] w, input logic [7:0] h,
                           input int spur, input int dafter);
        int exp_len;
        logic [1:0] exp_st;
        int en_cycles;
        bit got;
        run_model(spur, dafter, exp_len, exp_st);
        spur_cycles = spur;
        done_after  = dafter;
        @(negedge clk);
        drive_cmd(idx, x, y, w, h);
        #1;
        check("accept_ready", bus.req_ready, 32'(1) << idx);
        sb.push_back({idx[0], exp_st});
        @(negedge clk);
        bus.req_valid = 2'b00;
        check("setup_en", bus.rr_enable, 0);
        check("setup_busy", bus.busy, 1);
        check("geom_x", bus.rr_origin_x, x);
        check("geom_y", bus.rr_origin_y, y);
        check("geom_w", bus.rr_width, w);
        check("geom_h", bus.rr_height, h);
        check("color_back", bus.rr_back, idx + 2);
        en_cycles = 0;
        got = 0;
        for (int i = 0; i < TIMEOUT + 50 && !got; i++) begin
            @(negedge clk);
            if (i == 0) check("en_rise", bus.rr_enable, 1);
            if (bus.cmp_valid) begin
                got = 1;
                check("release_en", bus.rr_enable, 0);
                check("hold_w", bus.rr_width, w);
            end else if (bus.rr_enable) begin
                en_cycles++;
            end
        end
        check("cmp_seen", got, 1);
        check("run_len", en_cycles, exp_len);
        @(negedge clk);
        check("back_idle", bus.busy, 0);
    endtask

    task automatic skip_cmd(input int idx, input logic [8:0] x, input logic [7:0] y,
                            input logic [8:0] w, input logic [7:0] h);
        @(negedge clk);
        drive_cmd(idx, x, y, w, h);
        #1;
        check("skip_ready", bus.req_ready, 32'(1) << idx);
        sb.push_back({idx[0], 2'b01});
        @(negedge clk);
        check("skip_cmp", bus.cmp_valid, 1);
        check("skip_en", bus.rr_enable, 0);
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("skip_idle", bus.busy, 0);
        check("skip_en2", bus.rr_enable, 0);
    endtask

    initial begin
        int n;
        logic [1:0] exp_g[4];
        exp_g = '{2'd0, 2'd1, 2'd0, 2'd1};
        reset          = 1'b1;
        bus.req_valid  = '0;
        bus.req_x      = '0;
        bus.req_y      = '0;
        bus.req_w      = '0;
        bus.req_h      = '0;
        bus.req_back   = '0;
        bus.req_border = '0;
        bus.req_bcolor = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check("rst_cmp", bus.cmp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_en", bus.rr_enable, 0);
        check("rst_x", bus.rr_origin_x, 0);
        check("rst_w", bus.rr_width, 0);
        check("rst_status", bus.cmp_status, 0);
        check("rst_id", bus.cmp_id, 0);
        reset = 1'b0;

        run_cmd(0, 9'd10, 8'd20, 9'd4, 8'd3, 0, 12);
        run_cmd(1, 9'd0, 8'd0, 9'd1, 8'd1, 0, 1);

        do_reset();
        spur_cycles = 0;
        done_after  = 6;
        @(negedge clk);
        drive_cmd(0, 9'd1, 8'd1, 9'd2, 8'd2);
        drive_cmd(1, 9'd3, 8'd3, 9'd2, 8'd2);
        n = 0;
        for (int i = 0; i < 400 && n < 4; i++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                check("rr_order", bus.req_ready[1], exp_g[n]);
                sb.push_back({exp_g[n][0], 2'b00});
                n++;
            end
            if (n < 4) @(negedge clk);
        end
        check("rr_count", n, 4);
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_idle();

        skip_cmd(1, 9'd10, 8'd10, 9'd0, 8'd5);
        skip_cmd(1, 9'd320, 8'd10, 9'd5, 8'd5);
        skip_cmd(1, 9'd10, 8'd240, 9'd5, 8'd5);
        skip_cmd(0, 9'd10, 8'd10, 9'd5, 8'd0);

        run_cmd(0, 9'd0, 8'd0, 9'd320, 8'd240, 2, 1500);
        run_cmd(1, 9'd319, 8'd239, 9'd1, 8'd1, 0, 0);
        run_cmd(0, 9'd5, 8'd5, 9'd8, 8'd8, 0, TIMEOUT);

        spur_cycles = 0;
        done_after  = 0;
        @(negedge clk);
        drive_cmd(0, 9'd30, 8'd30, 9'd10, 8'd10);
        sb.push_back({1'b0, 2'b10});
        @(negedge clk);
        bus.req_valid = 2'b00;
        repeat (10) @(negedge clk);
        check("pre_rst_en", bus.rr_enable, 1);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("rst_en_async", bus.rr_enable, 0);
        check("rst_busy_async", bus.busy, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        done_after = 5;
        drive_cmd(0, 9'd2, 8'd2, 9'd3, 8'd3);
        drive_cmd(1, 9'd4, 8'd4, 9'd3, 8'd3);
        #1;
        check("post_rst_grant", bus.req_ready, 2'b01);
        sb.push_back({1'b0, 2'b00});
        @(negedge clk);
        bus.req_valid = 2'b00;
        wait_idle();
        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
